// File: rtl/echo_timer_if.sv
// Sensor-side signal bundle for the ultrasonic ranging front end.
// The timer side uses the master modport; a sensor model or the
// downstream converter uses the slave modport.
interface echo_timer_if #(
  parameter int WIDTH = 23
);
  logic             echo;         // raw sensor echo, asynchronous to clock
  logic             trigger;      // registered sensor trigger
  logic [WIDTH-1:0] echo_cycles;  // last good echo high-time, held
  logic             valid;        // 1-cycle pulse: echo_cycles updated
  logic             timeout;      // 1-cycle pulse: measurement aborted
  logic             busy;         // trigger / wait / measure in progress

  modport master (
    input  echo,
    output trigger, echo_cycles, valid, timeout, busy
  );

  modport slave (
    output echo,
    input  trigger, echo_cycles, valid, timeout, busy
  );
endinterface

// File: rtl/echo_timer.sv
// Ultrasonic ranging front end: periodic trigger generation, echo
// synchronisation and echo high-time measurement with timeout.
//
// Timing summary (cycles are clock periods):
//   - trigger rises on the second clock edge after reset release and then
//     every PERIOD_CYCLES; it stays high for TRIG_CYCLES.
//   - after trigger falls the echo rise is awaited for TIMEOUT_CYCLES+1
//     cycles; without a rise, timeout pulses TIMEOUT_CYCLES+1 cycles after
//     the trigger fall.
//   - valid pulses 3 cycles after the raw echo fall (2 sync + 1 register).
module echo_timer #(
  parameter int WIDTH          = 23,
  parameter int TRIG_CYCLES    = 500,
  parameter int PERIOD_CYCLES  = 3000000,
  parameter int TIMEOUT_CYCLES = 1200000
) (
  input  logic          clock,
  input  logic          reset,
  echo_timer_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    DONE
  } state_t;

  localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);
  localparam logic [WIDTH-1:0] TRIG_LAST   = WIDTH'(TRIG_CYCLES - 1);
  localparam logic [WIDTH-1:0] PERIOD_LAST = WIDTH'(PERIOD_CYCLES - 1);
  localparam logic [WIDTH-1:0] TIMEOUT_LIM = WIDTH'(TIMEOUT_CYCLES);

  state_t           state_q, state_d;
  logic             run_q;
  logic             echo_meta_q, echo_s_q, echo_d_q;
  logic             echo_rise;
  logic [WIDTH-1:0] period_q;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] echo_cycles_q, echo_cycles_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             trigger_q;
  logic             busy_q;

  // Two-flop synchroniser plus a delayed copy for edge detection.
  // NOTE: every flop is written with <= so all of them sample the values
  // from before the edge; with = the chain would collapse into one stage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      echo_meta_q <= 1'b0;
      echo_s_q    <= 1'b0;
      echo_d_q    <= 1'b0;
    end else begin
      echo_meta_q <= bus.echo;
      echo_s_q    <= echo_meta_q;
      echo_d_q    <= echo_s_q;
    end
  end

  assign echo_rise = echo_s_q & ~echo_d_q;

  // Run flag: low for the first cycle after release so IDLE lasts one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) run_q <= 1'b0;
    else       run_q <= 1'b1;
  end

  // Period counter: held at 0 in IDLE, counts from 0 on TRIG entry, wraps
  // at PERIOD_CYCLES-1 which is also the cycle that re-enters TRIG.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                          period_q <= '0;
    else if (state_q == IDLE || period_q == PERIOD_LAST) period_q <= '0;
    else                                                 period_q <= period_q + ONE;
  end

  // Next-state and datapath decisions for the measurement sequence.
  always_comb begin
    // NOTE: every variable gets its default before the case so no branch
    // can leave one unassigned and infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    echo_cycles_d = echo_cycles_q;
    valid_d       = 1'b0;
    timeout_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (run_q) state_d = TRIG;
      end
      TRIG: begin
        if (period_q == TRIG_LAST) begin
          state_d = WAIT_RISE;
          cnt_d   = '0;
        end
      end
      WAIT_RISE: begin
        // A level already high on entry has no 0->1 edge, so it is ignored.
        if (echo_rise) begin
          state_d = MEASURE;
          cnt_d   = ONE;
        end else if (cnt_q == TIMEOUT_LIM) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      MEASURE: begin
        if (!echo_s_q) begin
          state_d       = DONE;
          echo_cycles_d = cnt_q;
          valid_d       = 1'b1;
        end else if (cnt_q == TIMEOUT_LIM) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      DONE: begin
        if (period_q == PERIOD_LAST) state_d = TRIG;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      echo_cycles_q <= '0;
      valid_q       <= 1'b0;
      timeout_q     <= 1'b0;
      trigger_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      echo_cycles_q <= echo_cycles_d;
      valid_q       <= valid_d;
      timeout_q     <= timeout_d;
      trigger_q     <= (state_d == TRIG);
      busy_q        <= (state_d == TRIG) || (state_d == WAIT_RISE) || (state_d == MEASURE);
    end
  end

  assign bus.trigger     = trigger_q;
  assign bus.echo_cycles = echo_cycles_q;
  assign bus.valid       = valid_q;
  assign bus.timeout     = timeout_q;
  assign bus.busy        = busy_q;

endmodule
